// File: rtl/mult_err_stats.sv
// Error-statistics collector for an accurate or approximate 8x8 multiplier under test.
// Optional signed bias accumulator is enabled with the ERR_BIAS_EN macro.
module mult_err_stats #(
   parameter int unsigned NUM_SAMPLES = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_a,
   input  logic [7:0]         in_b,
   input  logic [15:0]        in_p,
   output logic [15:0]        sample_count,
   output logic [15:0]        mismatch_count,
   output logic [31:0]        sum_ed,
   output logic [15:0]        max_ed,
`ifdef ERR_BIAS_EN
   output logic signed [32:0] bias_sum,
`endif
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   localparam logic [15:0] LastIdx = 16'(NUM_SAMPLES - 1);

   state_e      state_q, state_d;
   logic [15:0] acc_cnt_q, acc_cnt_d;
   logic        s1_valid_q;
   logic [15:0] s1_ed_q;
   logic [15:0] exact;
   logic [15:0] ed;
   logic        xfer;
   logic        zero_stats;
`ifdef ERR_BIAS_EN
   logic signed [16:0] bias;
   logic signed [16:0] s1_bias_q;
`endif

   always_comb begin
      exact = {8'd0, in_a} * {8'd0, in_b};
      ed    = (in_p >= exact) ? (in_p - exact) : (exact - in_p);
`ifdef ERR_BIAS_EN
      bias  = signed'({1'b0, in_p}) - signed'({1'b0, exact});
`endif
   end

   always_comb begin
      state_d    = state_q;
      acc_cnt_d  = acc_cnt_q;
      zero_stats = 1'b0;
      in_ready   = (state_q == StRun);
      busy       = (state_q == StRun) || (state_q == StDrain);
      done       = (state_q == StDone);
      xfer       = in_valid && in_ready;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d    = StRun;
               acc_cnt_d  = 16'd0;
               zero_stats = 1'b1;
            end
         end
         StRun: begin
            if (xfer) begin
               acc_cnt_d = acc_cnt_q + 16'd1;
               if (acc_cnt_q == LastIdx) state_d = StDrain;
            end
         end
         StDrain: state_d = StDone;
         default: state_d = StIdle;
      endcase
   end

   // clear shares the reset path so an in-flight stage-1 sample is dropped
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q        <= StIdle;
         acc_cnt_q      <= 16'd0;
         s1_valid_q     <= 1'b0;
         s1_ed_q        <= 16'd0;
         sample_count   <= 16'd0;
         mismatch_count <= 16'd0;
         sum_ed         <= 32'd0;
         max_ed         <= 16'd0;
`ifdef ERR_BIAS_EN
         s1_bias_q      <= 17'sd0;
         bias_sum       <= 33'sd0;
`endif
      end else begin
         state_q    <= state_d;
         acc_cnt_q  <= acc_cnt_d;
         s1_valid_q <= xfer;
         if (xfer) begin
            s1_ed_q   <= ed;
`ifdef ERR_BIAS_EN
            s1_bias_q <= bias;
`endif
         end
         if (zero_stats) begin
            sample_count   <= 16'd0;
            mismatch_count <= 16'd0;
            sum_ed         <= 32'd0;
            max_ed         <= 16'd0;
`ifdef ERR_BIAS_EN
            bias_sum       <= 33'sd0;
`endif
         end else if (s1_valid_q) begin
            sample_count <= sample_count + 16'd1;
            if (s1_ed_q != 16'd0) mismatch_count <= mismatch_count + 16'd1;
            sum_ed <= sum_ed + {16'd0, s1_ed_q};
            if (s1_ed_q > max_ed) max_ed <= s1_ed_q;
`ifdef ERR_BIAS_EN
            bias_sum <= bias_sum + {{16{s1_bias_q[16]}}, s1_bias_q};
`endif
         end
      end
   end

endmodule

// File: doc/mult_err_stats.md
MULT_ERR_STATS -- requirements
Module: mult_err_stats

Interface
REQ-001 Parameter NUM_SAMPLES, default 256, number of samples per measurement run; legal range 1..65535.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse that begins a run.
REQ-005 clear  input  1  synchronous abort-and-zero, same effect as rst.
REQ-006 in_valid  input  1  sample presented on in_a/in_b/in_p.
REQ-007 in_ready  output  1  block accepts the sample this cycle.
REQ-008 in_a, in_b  input  8 each  unsigned multiplier operands.
REQ-009 in_p  input  16  product from the multiplier under test, accurate or approximate.
REQ-010 sample_count  output  16  samples accumulated so far.
REQ-011 mismatch_count  output  16  samples where in_p != in_a*in_b.
REQ-012 sum_ed  output  32  sum of |in_p - in_a*in_b|.
REQ-013 max_ed  output  16  largest single error distance.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  high in DONE.

Function
REQ-016 States are IDLE, RUN, DRAIN and DONE; reset state is IDLE.
REQ-017 A transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-018 in_ready is 1 only in RUN; it is 0 in IDLE, DRAIN and DONE.
REQ-019 Stage 1 registers, on a transfer edge, exact = in_a*in_b (16-bit, exact), ed = |in_p - exact|, and a stage-1 valid flag.
REQ-020 Stage 2 updates the accumulators one edge after stage 1 when that flag is set: sample_count+1, mismatch_count+1 if ed != 0, sum_ed+ed, max_ed = max(max_ed, ed).
REQ-021 Input-to-statistics latency is 2 edges; gaps in in_valid are tolerated with no loss and no double count.
REQ-022 sum_ed does not overflow (65025*65535 < 2^32), so no saturation logic is required.
REQ-023 From IDLE or DONE, start zeroes all statistics and enters RUN on the same edge.
REQ-024 start in RUN or DRAIN is ignored.
REQ-025 RUN moves to DRAIN on the edge that accepts the NUM_SAMPLES-th transfer.
REQ-026 DRAIN moves to DONE on the next edge, which is also the final accumulator update.
REQ-027 In DONE, statistics hold stable until start, clear or rst.
REQ-028 When NUM_SAMPLES=1, the first transfer moves RUN to DRAIN directly.
REQ-029 clear or rst in any state, including mid-RUN with a sample in stage 1, discards the in-flight sample and enters IDLE.
REQ-030 If clear and start are both high, clear wins.

Reset
REQ-031 On rst: state IDLE, in_ready=0, busy=0, done=0, all statistics 0, stage-1 valid 0, internal acceptance counter 0.

Configuration
REQ-032 Macro ERR_BIAS_EN, when defined, adds output bias_sum (33-bit signed) that accumulates the signed value (in_p - exact) alongside sum_ed, with the same timing and the same zeroing on reset, clear and start.
REQ-033 Without ERR_BIAS_EN, the port and its logic are absent; all other behaviour is identical.

Verification
REQ-034 NUM_SAMPLES=4; samples (0,0,0), (255,1,255), (12,15,180), (100,200,20000) -> DONE with sample_count=4, mismatch_count=0, sum_ed=0, max_ed=0.
REQ-035 NUM_SAMPLES=3; samples (255,255,0), (128,128,16384), (50,5,256) -> mismatch_count=2, sum_ed=65031, max_ed=65025; with ERR_BIAS_EN, bias_sum=-65019.
REQ-036 NUM_SAMPLES=2 with in_valid toggling every other cycle -> exactly 2 samples counted; done rises 2 edges after the 2nd transfer; in_ready=0 from the DRAIN edge onward.
REQ-037 clear asserted 1 cycle after a transfer in RUN -> next cycle IDLE, all statistics 0, that sample never counted.
REQ-038 start pulsed during RUN -> ignored, no change to counts; start in DONE -> statistics zeroed and state RUN on the same edge.
REQ-039 NUM_SAMPLES=1, sample (12,15,176) -> DONE with sample_count=1, mismatch_count=1, sum_ed=4, max_ed=4.
